csi2_raw10_depacketizer: RTL and testbench
==========================================

Name: csi2_raw10_depacketizer

Overview:
Converts the merged 2-lane CSI-2 byte stream from the D-PHY receiver into the 4-pixel RAW10 words and frame/line sync strobes consumed by the image write path. It parses packet headers, tracks frame state, filters by virtual channel and unpacks RAW10 payload (5 bytes -> 4 pixels). It sits directly upstream of the pixel-clock CDC FIFO stage, inside the MIPI PHY wrapper on the video clock.

Parameters:
VC, 2'd0, virtual channel accepted; other VCs silently skipped
DT_RAW10, 6'h2B, data type unpacked as pixels
WC_W, 16, word-count width

Ports:
clk  in  1  video clock; all logic on rising edge
reset  in  1  synchronous, active-high
in_data  in  16  merged lane bytes; [7:0]=lane0 (earlier byte), [15:8]=lane1
in_valid  in  1  high for each beat of an HS burst; falling = EoT
pix_data  out  40  [39:30]=P0 … [9:0]=P3, P0 first on the line
line_valid  out  1  one-cycle strobe per valid pix_data word
sync_word  out  10  {2'b00, DataID} of last accepted header
sync_sof  out  1  pulse on FS
sync_sol  out  1  pulse on accepted RAW10 line header
sync_eol  out  1  pulse with final group of a line
sync_eof  out  1  pulse on FE
sync_error  out  1  pulse per protocol error

Behaviour:
- Reset: all outputs 0, pix_data 0, in_frame 0, accumulator empty, state S_WAIT_EOT (never lock onto a mid-burst beat).
- One packet per HS burst. States: S_HDR0, S_HDR1, S_PAYLOAD, S_CRC, S_WAIT_EOT.
- S_WAIT_EOT: ignore beats; in_valid==0 -> S_HDR0.
- S_HDR0: on in_valid, latch DataID=in_data[7:0], WC[7:0]=in_data[15:8] -> S_HDR1.
- S_HDR1: on in_valid latch WC[15:8]=in_data[7:0]; ECC ([15:8]) ignored. Decode (registered; strobes appear cycle after this beat):
  - VC!=param -> S_WAIT_EOT, no pulse, no error.
  - DT 00 FS: sync_sof, in_frame<=1 (FS while in_frame restarts frame, no error). DT 01 FE: sync_eof, in_frame<=0. DT 02/03 and other DT<0x10: no pulse. All short -> S_WAIT_EOT.
  - DT==DT_RAW10: WC==0 or WC%10!=0 or in_frame==0 -> sync_error, S_WAIT_EOT. Else sync_sol, clear accumulator, remaining<=WC, -> S_PAYLOAD.
  - Any other DT: S_WAIT_EOT silently.
  - sync_word updated on every decoded header (including skipped VC).
- S_PAYLOAD: each in_valid beat appends 2 bytes (lane0 first) to a 6-byte accumulator, remaining-=2. When count>=5, emit group next cycle: Pk[9:2]=byte k, Pk[1:0]=byte4[2k+1:2k]; count-=5. Max one group per beat; count never exceeds 6. Beat with remaining==2 -> S_CRC; its group carries sync_eol with line_valid.
- S_CRC: one beat consumed, CRC not checked -> S_WAIT_EOT.
- in_valid low during S_HDR1/S_PAYLOAD/S_CRC: sync_error pulse, accumulator cleared, partial group discarded, no sync_eol, -> S_HDR0.
- Latency: pixel group/strobes 1 cycle after completing beat. pix_data holds last value between strobes.
- Reset mid-packet: immediate return to reset state; subsequent beats of that burst ignored.

Test Plan:
- FS: beats 16'h0100,16'h0000 then EoT -> sync_sof 1 cycle after beat 2, sync_word=10'h000, no error.
- RAW10 line after FS: 16'h0A2B,16'h0000,16'h4080,16'h1020,16'hFF1B,16'hFFFF,16'hFFFF,CRC -> line_valid after 3rd payload beat with pix_data={10'h203,10'h102,10'h081,10'h040}; after 5th with 40'hFF_FFFF_FFFF plus sync_eol; sync_sol after header.
- WC=12 (16'h0C2B,16'h0000) -> sync_error once, no line_valid, rest of burst ignored.
- EoT after 2 payload beats of 10-byte line -> sync_error, no line_valid/sync_eol; next FE (16'h0001,16'h0000) -> sync_eof.
- DataID 8'h6B (VC1) with VC=0 -> no strobes, no error, sync_word=10'h06B.
- reset asserted mid-payload with in_valid held high -> all outputs 0; remaining beats produce nothing until in_valid drops and a new FS arrives.

Source files
------------

// File: rtl/csi2_raw10_depacketizer.sv
// CSI-2 2-lane byte stream -> RAW10 4-pixel words plus frame/line sync strobes.
// One packet per HS burst; the header is decoded on its second beat and all outputs are registered.
module csi2_raw10_depacketizer #(
    parameter logic [1:0] VC       = 2'd0,
    parameter logic [5:0] DT_RAW10 = 6'h2B,
    parameter int         WC_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic [39:0] pix_data,
    output logic        line_valid,
    output logic [9:0]  sync_word,
    output logic        sync_sof,
    output logic        sync_sol,
    output logic        sync_eol,
    output logic        sync_eof,
    output logic        sync_error
);
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_PAYLOAD, S_CRC, S_WAIT_EOT} state_t;

    localparam logic [WC_W-1:0] TEN = WC_W'(10);
    localparam logic [WC_W-1:0] TWO = WC_W'(2);

    state_t            state_q, state_d;
    logic [7:0]        dataid_q, dataid_d;
    logic [7:0]        wclo_q, wclo_d;
    logic              in_frame_q, in_frame_d;
    logic [5:0][7:0]   acc_q, acc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WC_W-1:0]   rem_q, rem_d;
    logic [39:0]       pix_q, pix_d;
    logic [9:0]        word_q, word_d;
    logic              lv_q, lv_d, sof_q, sof_d, sol_q, sol_d;
    logic              eol_q, eol_d, eof_q, eof_d, err_q, err_d;

    logic [WC_W-1:0]   wc;
    logic [5:0][7:0]   app;
    logic [3:0]        tot;

    assign wc = WC_W'({in_data[7:0], wclo_q});

    always_comb begin
        state_d    = state_q;
        dataid_d   = dataid_q;
        wclo_d     = wclo_q;
        in_frame_d = in_frame_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        pix_d      = pix_q;
        word_d     = word_q;
        lv_d       = 1'b0;
        sof_d      = 1'b0;
        sol_d      = 1'b0;
        eol_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;

        // Accumulator with this beat's two bytes appended, lane0 first.
        app = acc_q;
        tot = {1'b0, cnt_q} + 4'd2;
        for (int i = 0; i < 6; i++) begin
            if (i == int'(cnt_q))
                app[i] = in_data[7:0];
            else if (i == int'(cnt_q) + 1)
                app[i] = in_data[15:8];
        end

        case (state_q)
            S_WAIT_EOT: begin
                if (!in_valid) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (in_valid) begin
                    dataid_d = in_data[7:0];
                    wclo_d   = in_data[15:8];
                    state_d  = S_HDR1;
                end
            end
            S_HDR1, S_PAYLOAD, S_CRC: begin
                if (!in_valid) begin
                    // Burst ended early: drop any partial group.
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_HDR0;
                end else if (state_q == S_HDR1) begin
                    word_d  = {2'b00, dataid_q};
                    state_d = S_WAIT_EOT;
                    if (dataid_q[7:6] == VC) begin
                        if (dataid_q[5:0] == 6'h00) begin
                            sof_d      = 1'b1;
                            in_frame_d = 1'b1;
                        end else if (dataid_q[5:0] == 6'h01) begin
                            eof_d      = 1'b1;
                            in_frame_d = 1'b0;
                        end else if (dataid_q[5:0] == DT_RAW10) begin
                            if (wc == '0 || (wc % TEN) != '0 || !in_frame_q) begin
                                err_d = 1'b1;
                            end else begin
                                sol_d   = 1'b1;
                                acc_d   = '0;
                                cnt_d   = '0;
                                rem_d   = wc;
                                state_d = S_PAYLOAD;
                            end
                        end
                    end
                end else if (state_q == S_PAYLOAD) begin
                    rem_d = rem_q - TWO;
                    if (tot >= 4'd5) begin
                        pix_d = {app[0], app[4][1:0], app[1], app[4][3:2],
                                 app[2], app[4][5:4], app[3], app[4][7:6]};
                        lv_d  = 1'b1;
                        acc_d = '0;
                        acc_d[0] = app[5];
                        cnt_d = 3'(tot - 4'd5);
                    end else begin
                        acc_d = app;
                        cnt_d = tot[2:0];
                    end
                    if (rem_q == TWO) begin
                        eol_d   = tot >= 4'd5;
                        state_d = S_CRC;
                    end
                end else begin
                    state_d = S_WAIT_EOT;
                end
            end
            default: state_d = S_WAIT_EOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WAIT_EOT;
            dataid_q   <= '0;
            wclo_q     <= '0;
            in_frame_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            pix_q      <= '0;
            word_q     <= '0;
            lv_q       <= 1'b0;
            sof_q      <= 1'b0;
            sol_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dataid_q   <= dataid_d;
            wclo_q     <= wclo_d;
            in_frame_q <= in_frame_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            pix_q      <= pix_d;
            word_q     <= word_d;
            lv_q       <= lv_d;
            sof_q      <= sof_d;
            sol_q      <= sol_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
        end
    end

    assign pix_data   = pix_q;
    assign line_valid = lv_q;
    assign sync_word  = word_q;
    assign sync_sof   = sof_q;
    assign sync_sol   = sol_q;
    assign sync_eol   = eol_q;
    assign sync_eof   = eof_q;
    assign sync_error = err_q;
endmodule

// File: tb/tb_csi2_raw10_depacketizer.sv
// Directed bench for csi2_raw10_depacketizer: hand-computed packets, strobe timing and pulse counts.
module tb_csi2_raw10_depacketizer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [39:0] pix_data;
    logic        line_valid;
    logic [9:0]  sync_word;
    logic        sync_sof, sync_sol, sync_eol, sync_eof, sync_error;

    localparam logic [39:0] PIX1 = {10'h203, 10'h102, 10'h081, 10'h040};
    localparam logic [39:0] PIX2 = 40'hFF_FFFF_FFFF;

    always #5 clk = ~clk;

    csi2_raw10_depacketizer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .pix_data(pix_data), .line_valid(line_valid), .sync_word(sync_word),
        .sync_sof(sync_sof), .sync_sol(sync_sol), .sync_eol(sync_eol),
        .sync_eof(sync_eof), .sync_error(sync_error)
    );

    // Pulse counters, sampled mid-cycle.
    int n_sof = 0, n_sol = 0, n_eol = 0, n_eof = 0, n_err = 0, n_lv = 0;
    always @(negedge clk) begin
        if (sync_sof)   n_sof++;
        if (sync_sol)   n_sol++;
        if (sync_eol)   n_eol++;
        if (sync_eof)   n_eof++;
        if (sync_error) n_err++;
        if (line_valid) n_lv++;
    end

    int b_sof, b_sol, b_eol, b_eof, b_err, b_lv;
    int total = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = '0;
        end
    endtask

    task automatic snap();
        #1;
        b_sof = n_sof; b_sol = n_sol; b_eol = n_eol;
        b_eof = n_eof; b_err = n_err; b_lv = n_lv;
    endtask

    task automatic chk_cnts(input string tag, input int sof, input int sol, input int eol,
                            input int eof, input int err, input int lv);
        #1;
        chk({tag, "_cnt_sof"}, 64'(n_sof - b_sof), 64'(sof));
        chk({tag, "_cnt_sol"}, 64'(n_sol - b_sol), 64'(sol));
        chk({tag, "_cnt_eol"}, 64'(n_eol - b_eol), 64'(eol));
        chk({tag, "_cnt_eof"}, 64'(n_eof - b_eof), 64'(eof));
        chk({tag, "_cnt_err"}, 64'(n_err - b_err), 64'(err));
        chk({tag, "_cnt_lv"},  64'(n_lv - b_lv),   64'(lv));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pix", 64'(pix_data), 64'd0);
        chk("rst_word", 64'(sync_word), 64'd0);
        chk("rst_strobes", 64'({line_valid, sync_sof, sync_sol, sync_eol, sync_eof, sync_error}), 64'd0);
        reset = 1'b0;
        idle(2);
        snap();

        // Frame start
        beat(16'h0100); beat(16'h0000); idle(1);
        chk("fs_sof", 64'(sync_sof), 64'd1);
        chk("fs_word", 64'(sync_word), 64'h000);
        chk("fs_err", 64'(sync_error), 64'd0);
        idle(1);
        chk("fs_sof_pulse", 64'(sync_sof), 64'd0);
        idle(2);
        chk_cnts("fs", 1, 0, 0, 0, 0, 0);
        snap();

        // RAW10 line, WC=10
        beat(16'h0A2B); beat(16'h0000); beat(16'h4080);
        chk("ln_sol", 64'(sync_sol), 64'd1);
        chk("ln_word", 64'(sync_word), 64'h02B);
        beat(16'h1020); beat(16'hFF1B); beat(16'hFFFF);
        chk("ln_lv1", 64'(line_valid), 64'd1);
        chk("ln_pix1", 64'(pix_data), 64'(PIX1));
        chk("ln_eol1", 64'(sync_eol), 64'd0);
        beat(16'hFFFF); beat(16'h1234);
        chk("ln_lv2", 64'(line_valid), 64'd1);
        chk("ln_pix2", 64'(pix_data), 64'(PIX2));
        chk("ln_eol2", 64'(sync_eol), 64'd1);
        idle(1);
        chk("ln_lv_off", 64'(line_valid), 64'd0);
        chk("ln_pix_hold", 64'(pix_data), 64'(PIX2));
        idle(2);
        chk_cnts("ln", 0, 1, 1, 0, 0, 2);
        snap();

        // Bad word count (12): error, rest of burst ignored
        beat(16'h0C2B); beat(16'h0000); beat(16'h4080);
        chk("wc12_err", 64'(sync_error), 64'd1);
        chk("wc12_sol", 64'(sync_sol), 64'd0);
        beat(16'h1020); beat(16'hFF1B); beat(16'hFFFF);
        idle(3);
        chk_cnts("wc12", 0, 0, 0, 0, 1, 0);
        snap();

        // Early EoT after two payload beats
        beat(16'h0A2B); beat(16'h0000); beat(16'h4080); beat(16'h1020);
        idle(2);
        chk("eot_err", 64'(sync_error), 64'd1);
        chk("eot_eol", 64'(sync_eol), 64'd0);
        idle(2);
        chk_cnts("eot", 0, 1, 0, 0, 1, 0);
        snap();

        // Frame end
        beat(16'h0001); beat(16'h0000); idle(1);
        chk("fe_eof", 64'(sync_eof), 64'd1);
        chk("fe_word", 64'(sync_word), 64'h001);
        idle(2);
        chk_cnts("fe", 0, 0, 0, 1, 0, 0);
        snap();

        // Line outside a frame is a protocol error
        beat(16'h0A2B); beat(16'h0000); beat(16'h4080);
        chk("nof_err", 64'(sync_error), 64'd1);
        chk("nof_sol", 64'(sync_sol), 64'd0);
        idle(3);
        snap();

        // Other virtual channel: silently skipped, sync_word still updated
        beat(16'h0A6B); beat(16'h0000); idle(1);
        chk("vc1_word", 64'(sync_word), 64'h06B);
        idle(3);
        chk_cnts("vc1", 0, 0, 0, 0, 0, 0);
        snap();

        // Reset mid-payload with the burst continuing
        beat(16'h0100); beat(16'h0000); idle(1);
        beat(16'h0A2B); beat(16'h0000); beat(16'h4080); beat(16'h1020);
        @(negedge clk); reset = 1'b1; in_data = 16'hFF1B;
        @(negedge clk); in_data = 16'hFFFF;
        chk("mrst_pix", 64'(pix_data), 64'd0);
        chk("mrst_strobes", 64'({line_valid, sync_sof, sync_sol, sync_eol, sync_eof, sync_error}), 64'd0);
        chk("mrst_word", 64'(sync_word), 64'd0);
        @(negedge clk); reset = 1'b0; in_data = 16'hFFFF;
        beat(16'h0100); beat(16'h0000); beat(16'h4080); beat(16'h1020);
        beat(16'hFF1B); beat(16'hFFFF);
        idle(3);
        chk_cnts("mrst", 1, 1, 0, 0, 0, 0);
        chk("mrst_pix_after", 64'(pix_data), 64'd0);
        snap();

        // New FS after the burst ends is accepted again
        beat(16'h0100); beat(16'h0000); idle(1);
        chk("refs_sof", 64'(sync_sof), 64'd1);
        idle(2);
        chk_cnts("refs", 1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
